// File: rtl/entrada_pkg.sv
// entrada_pkg -- shared types and constants for the entrada input-stack controller.
//   state_t : controller FSM states
//   tag_t   : who asked for a pop (CPU instruction or manual button)
//   pend_t  : one-deep deferred push (valid + captured switch word)
package entrada_pkg;

  localparam int STK_DEPTH = 16;
  localparam int CNT_W     = $clog2(STK_DEPTH) + 1;
  localparam int SW_W      = 16;
  localparam int CPU_W     = 32;

  // Button lanes of the debounce array
  localparam int NUM_BTN   = 2;
  localparam int BTN_PUSH  = 0;
  localparam int BTN_POP   = 1;

  typedef enum logic [1:0] {IDLE, POP, CAPTURE, ACK} state_t;
  typedef enum logic {CPU, MANUAL} tag_t;

  typedef struct packed {
    logic            vld;
    logic [SW_W-1:0] data;
  } pend_t;

endpackage

// File: rtl/switch_debounce.sv
// switch_debounce -- synchronizer, debounce counter and rising-edge detect
// for one raw push-button.
//   clk, reset : clock, synchronous active-high reset
//   sw         : raw asynchronous button level
//   rise       : one-cycle pulse when the debounced level goes 0 -> 1
module switch_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic rise
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   level;
  logic                   level_q;
  logic                   sync_out;

  assign sync_out = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync    <= (sync << 1) | SYNC_STAGES'(sw);
      level_q <= level;
      // cnt counts consecutive samples that disagree with the current level;
      // any agreeing sample (a glitch ending) restarts the count.
      if (sync_out == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= sync_out;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/entrada_ctrl.sv
// entrada_ctrl -- sequences the LIFO input stack between board switches and CPU.
//   clk, reset            : clock, synchronous active-high reset
//   sw_push, sw_pop       : raw buttons (debounced internally)
//   data_sw               : switch word pushed on a push press
//   cpu_req/cpu_ack       : CPU input handshake; cpu_stall while unanswered
//   cpu_data, disp_data   : last word popped for CPU / for manual display
//   stk_push/pop/clear    : one-hot strobes to the stack, stk_din its data
//   stk_dout              : stack output, valid the cycle after stk_pop
//   count, full, empty    : occupancy as seen after the strobes have landed
//   ovf_err               : sticky, a push was dropped because the stack was full
module entrada_ctrl
  import entrada_pkg::*;
#(
  parameter int DEPTH       = STK_DEPTH,
  parameter int DB_CYCLES   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sw_push,
  input  logic                   sw_pop,
  input  logic [SW_W-1:0]        data_sw,
  input  logic                   cpu_req,
  output logic                   cpu_ack,
  output logic                   cpu_stall,
  output logic [CPU_W-1:0]       cpu_data,
  output logic [CPU_W-1:0]       disp_data,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic                   stk_clear,
  output logic [SW_W-1:0]        stk_din,
  input  logic [CPU_W-1:0]       stk_dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf_err
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_rise;
  logic               push_ev;
  logic               pop_ev;
  logic [CW-1:0]      occ;
  logic               push_ok;
  logic               clr_q;
  state_t             state;
  tag_t               tag;
  pend_t              pend;

  assign btn_raw = {sw_pop, sw_push};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    switch_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .sw    (btn_raw[g]),
      .rise  (btn_rise[g])
    );
  end

  assign push_ev = btn_rise[BTN_PUSH];
  assign pop_ev  = btn_rise[BTN_POP];

  // count lags the strobes by a cycle; the overflow guard uses the occupancy
  // including strobes still in flight so a back-to-back push can never overrun.
  assign occ     = count + CW'(stk_push) - CW'(stk_pop);
  assign push_ok = occ < DEPTH_C;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign cpu_stall = cpu_req & ~cpu_ack;

  // Clear strobe only in the first cycle with reset released.
  always_ff @(posedge clk) clr_q <= reset;
  assign stk_clear = clr_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tag       <= CPU;
      count     <= '0;
      pend      <= '0;
      ovf_err   <= 1'b0;
      cpu_data  <= '0;
      disp_data <= '0;
      cpu_ack   <= 1'b0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_din   <= '0;
    end else begin
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      cpu_ack  <= 1'b0;
      count    <= count + CW'(stk_push) - CW'(stk_pop);

      case (state)
        IDLE: begin
          // A push (fresh or deferred) owns the cycle; any pop waits a cycle.
          // A fresh push_ev colliding with a deferred one is dropped.
          if (pend.vld || push_ev) begin
            pend.vld <= 1'b0;
            if (push_ok) begin
              stk_push <= 1'b1;
              stk_din  <= pend.vld ? pend.data : data_sw;
            end else begin
              ovf_err <= 1'b1;
            end
          end else if (cpu_req && !empty) begin
            state   <= POP;
            tag     <= CPU;
            stk_pop <= 1'b1;
          end else if (pop_ev && !empty) begin
            state   <= POP;
            tag     <= MANUAL;
            stk_pop <= 1'b1;
          end
        end
        POP: state <= CAPTURE;
        CAPTURE: begin
          if (tag == CPU) begin
            cpu_data <= stk_dout;
            cpu_ack  <= 1'b1;
            state    <= ACK;
          end else begin
            disp_data <= stk_dout;
            state     <= IDLE;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase

      // Busy: hold one push for the next IDLE cycle, drop any further ones.
      if (state != IDLE && push_ev && !pend.vld) begin
        pend.vld  <= 1'b1;
        pend.data <= data_sw;
      end
    end
  end

endmodule

// File: tb/tb_entrada_ctrl.sv
// tb_entrada_ctrl -- directed/randomized bench for entrada_ctrl. An external
// LIFO stand-in answers the strobes; expected values come from a queue model
// of what the stack should hold after each button press or CPU request.
module tb_entrada_ctrl;

  localparam int DEPTH = 16;
  localparam int DB    = 4;
  localparam int SS    = 2;
  localparam int LAT   = SS + DB + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sw_push = 1'b0;
  logic        sw_pop = 1'b0;
  logic        cpu_req = 1'b0;
  logic [15:0] data_sw = '0;
  logic        cpu_ack, cpu_stall, stk_push, stk_pop, stk_clear, full, empty, ovf_err;
  logic [31:0] cpu_data, disp_data;
  logic [31:0] stk_dout = '0;
  logic [15:0] stk_din;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;
  int n_push = 0, n_pop = 0, n_clr = 0, n_multi = 0;

  logic [15:0] mem[$];     // contents of the stand-in stack
  logic [15:0] exp_q[$];   // expected stack contents
  bit          exp_ovf = 1'b0;
  logic [31:0] exp_disp = '0;

  // capture-window scratch
  int          pa, pp, ak, run, p0, q0;
  logic [15:0] r, din_c, e;
  logic [31:0] got;

  entrada_ctrl #(.DEPTH(DEPTH), .DB_CYCLES(DB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .sw_push(sw_push), .sw_pop(sw_pop), .data_sw(data_sw),
    .cpu_req(cpu_req), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall), .cpu_data(cpu_data),
    .disp_data(disp_data), .stk_push(stk_push), .stk_pop(stk_pop), .stk_clear(stk_clear),
    .stk_din(stk_din), .stk_dout(stk_dout), .count(count), .full(full), .empty(empty),
    .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  // Stand-in stack: output valid the cycle after the pop strobe.
  always @(posedge clk) begin
    if (stk_clear) mem.delete();
    else begin
      if (stk_push) mem.push_back(stk_din);
      if (stk_pop) begin
        if (mem.size() > 0) stk_dout <= {16'h0, mem.pop_back()};
        else                stk_dout <= 32'hDEAD_0000;
      end
    end
  end

  always @(negedge clk) begin
    if (stk_push === 1'b1) n_push++;
    if (stk_pop === 1'b1) n_pop++;
    if (stk_clear === 1'b1) n_clr++;
    if ((int'(stk_push === 1'b1) + int'(stk_pop === 1'b1) + int'(stk_clear === 1'b1)) > 1) n_multi++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_occ(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    chk({tag, "_full"},  32'(full),  32'(exp_q.size() == DEPTH));
    chk({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
    chk({tag, "_ovf"},   32'(ovf_err), 32'(exp_ovf));
  endtask

  // Press and release one button; lat = cycles from press to strobe, -1 if none.
  task automatic press(input bit is_pop, input logic [15:0] d, output int lat, output logic [15:0] din);
    lat = -1;
    din = '0;
    data_sw = d;
    if (is_pop) sw_pop = 1'b1; else sw_push = 1'b1;
    for (int i = 1; i <= LAT + 8; i++) begin
      tick();
      if (is_pop ? stk_pop : stk_push) begin
        lat = i;
        din = stk_din;
        break;
      end
    end
    sw_pop = 1'b0;
    sw_push = 1'b0;
    repeat (LAT + 8) tick();
  endtask

  task automatic push_step(input logic [15:0] d, input string tag);
    int lat;
    logic [15:0] din;
    press(1'b0, d, lat, din);
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(d);
      chk({tag, "_lat"}, lat, LAT);
      chk({tag, "_din"}, 32'(din), 32'(d));
    end else begin
      exp_ovf = 1'b1;
      chk({tag, "_drop"}, lat, -1);
    end
    check_occ(tag);
  endtask

  task automatic mpop_step(input string tag);
    int lat;
    logic [15:0] din;
    press(1'b1, 16'h0, lat, din);
    if (exp_q.size() > 0) begin
      exp_disp = {16'h0, exp_q.pop_back()};
      chk({tag, "_lat"}, lat, LAT);
    end else begin
      chk({tag, "_drop"}, lat, -1);
    end
    chk({tag, "_disp"}, disp_data, exp_disp);
    check_occ(tag);
  endtask

  task automatic req_step(input string tag);
    int lat;
    int p;
    logic [31:0] g;
    logic [15:0] x;
    lat = -1;
    g = '0;
    p = n_pop;
    cpu_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) chk({tag, "_stall"}, 32'(cpu_stall), 1);
      if (cpu_ack) begin
        lat = i;
        g = cpu_data;
        break;
      end
    end
    cpu_req = 1'b0;
    tick();
    x = exp_q.pop_back();
    chk({tag, "_acklat"}, lat, 3);
    chk({tag, "_data"}, g, {16'h0, x});
    chk({tag, "_npop"}, n_pop - p, 1);
    check_occ(tag);
  endtask

  // CPU waits on an empty stack, then one push feeds it.
  task automatic empty_req_push(input logic [15:0] d, input string tag);
    int m, al, p;
    logic [31:0] g;
    m = -1;
    al = -1;
    g = '0;
    p = n_pop;
    cpu_req = 1'b1;
    repeat (6) tick();
    chk({tag, "_stall"}, 32'(cpu_stall), 1);
    chk({tag, "_nopop"}, n_pop - p, 0);
    data_sw = d;
    sw_push = 1'b1;
    for (int i = 1; i <= LAT + 8; i++) begin
      tick();
      if (stk_push) begin
        m = i;
        break;
      end
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (cpu_ack) begin
        al = i;
        g = cpu_data;
        break;
      end
    end
    cpu_req = 1'b0;
    sw_push = 1'b0;
    chk({tag, "_pushlat"}, m, LAT);
    chk({tag, "_acklat"}, al, 4);
    chk({tag, "_data"}, g, {16'h0, d});
    chk({tag, "_cnt_at_ack"}, 32'(count), 0);
    repeat (LAT + 8) tick();
    check_occ(tag);
  endtask

  initial begin
    // ---- reset ----
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    chk("rst_ack", 32'(cpu_ack), 0);
    chk("rst_push", 32'(stk_push), 0);
    chk("rst_pop", 32'(stk_pop), 0);
    chk("rst_clear_held", 32'(stk_clear), 0);
    chk("rst_cpu_data", cpu_data, 0);
    chk("rst_disp_data", disp_data, 0);
    reset = 1'b0;
    #1;
    chk("clear_first", 32'(stk_clear), 1);
    tick();
    chk("clear_after", 32'(stk_clear), 0);

    // ---- basic pushes and CPU reads ----
    push_step(16'h00A5, "p_a5");
    push_step(16'h0001, "p1");
    push_step(16'h0002, "p2");
    push_step(16'h0003, "p3");
    req_step("req3");
    req_step("req2");
    mpop_step("mpop1");

    // ---- fill with random words, then overflow ----
    while (exp_q.size() < DEPTH) push_step(16'($urandom), "fill");
    push_step(16'($urandom), "ovf17");
    chk("nclr_once", n_clr, 1);

    // ---- drain via CPU, LIFO order; ovf_err stays set ----
    while (exp_q.size() > 0) req_step("drain");
    mpop_step("mpop_empty");

    // ---- CPU stalls on empty stack ----
    empty_req_push(16'($urandom), "stall");

    // ---- push arrives during CAPTURE while sw_pop bounces ----
    push_step(16'($urandom), "pre_cap");
    r = 16'($urandom);
    data_sw = r;
    sw_push = 1'b1;
    repeat (4) tick();
    p0 = n_pop;
    q0 = n_push;
    pa = -1; pp = -1; ak = -1; run = 0;
    got = '0;
    din_c = '0;
    cpu_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (stk_pop && pp < 0) pp = k;
      if (cpu_ack && ak < 0) begin
        ak = k;
        got = cpu_data;
        cpu_req = 1'b0;
      end
      if (stk_push && pa < 0) begin
        pa = k;
        din_c = stk_din;
      end
      if (run >= 2) sw_pop = 1'b0;
      else          sw_pop = 1'($urandom_range(0, 1));
      run = sw_pop ? run + 1 : 0;
    end
    sw_pop = 1'b0;
    sw_push = 1'b0;
    e = exp_q.pop_back();
    exp_q.push_back(r);
    chk("cap_pop_at", pp, 1);
    chk("cap_ack_at", ak, 3);
    chk("cap_data", got, {16'h0, e});
    chk("cap_push_at", pa, 5);
    chk("cap_push_din", 32'(din_c), 32'(r));
    repeat (LAT + 8) tick();
    chk("cap_npush", n_push - q0, 1);
    chk("cap_npop", n_pop - p0, 1);
    check_occ("cap");
    mpop_step("mpop_deferred");

    // ---- reset while the FSM is in CAPTURE ----
    push_step(16'($urandom), "pre_rst_a");
    push_step(16'($urandom), "pre_rst_b");
    cpu_req = 1'b1;
    tick();
    chk("rstcap_pop", 32'(stk_pop), 1);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rstcap_noack", 32'(cpu_ack), 0);
    end
    chk("rstcap_count", 32'(count), 0);
    reset = 1'b0;
    #1;
    chk("rstcap_clear", 32'(stk_clear), 1);
    exp_q.delete();
    exp_ovf = 1'b0;
    tick();
    chk("rstcap_clear_off", 32'(stk_clear), 0);
    check_occ("rstcap");
    empty_req_push(16'($urandom), "rstcap_reserve");

    chk("nclr_total", n_clr, 2);
    chk("one_hot_strobes", n_multi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
